alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters, e.g. the execute-stage issue path (port 0) and an auxiliary address/iterative unit (port 1).
- Each requester uses a valid/ready request handshake and receives its own registered response with backpressure.
- Arbitration is round-robin. The block drives the ALU operand and ctrl inputs and captures alu_out and overflow.

---
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU between two
// requesters, each with a valid/ready request and a registered response.
//
// Ports:
//   clk, reset             clock (rising edge), async active-high reset
//   req_valid/req_ready    per-port request handshake (ready is combinational)
//   req_a_*/req_b_*        per-port operands
//   req_ctrl_*             per-port ALU op
//   resp_valid/resp_ready  per-port response handshake
//   resp_out_*/resp_ovf    per-port registered ALU result and overflow
//   alu_a/alu_b/alu_ctrl   drive to the shared ALU
//   alu_out/alu_overflow   same-cycle result from the shared ALU

`ifndef aluAdd
`define aluAdd 4'h0
`endif
`ifndef aluSub
`define aluSub 4'h1
`endif
`ifndef aluShiftLeft
`define aluShiftLeft 4'h2
`endif
`ifndef aluArithmeticShiftRight
`define aluArithmeticShiftRight 4'h3
`endif
`ifndef aluDisabled
`define aluDisabled 4'hF
`endif

module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4,
  parameter logic [CTRL_WIDTH-1:0] IDLE_CTRL = `aluDisabled
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req_a_0,
  input  logic [DATA_WIDTH-1:0] req_a_1,
  input  logic [DATA_WIDTH-1:0] req_b_0,
  input  logic [DATA_WIDTH-1:0] req_b_1,
  input  logic [CTRL_WIDTH-1:0] req_ctrl_0,
  input  logic [CTRL_WIDTH-1:0] req_ctrl_1,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0] resp_out_0,
  output logic [DATA_WIDTH-1:0] resp_out_1,
  output logic [1:0]            resp_ovf,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [CTRL_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_overflow
);

  logic       last_grant;
  logic [1:0] elig;
  logic [1:0] grant;

  // A port holding an undrained response cannot take a new result.
  assign elig = req_valid & (~resp_valid | resp_ready);

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      unique case (elig)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // Tie: favour the port that did not win last time.
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = IDLE_CTRL;
    unique case (1'b1)
      grant[0]: begin
        alu_a    = req_a_0;
        alu_b    = req_b_0;
        alu_ctrl = req_ctrl_0;
      end
      grant[1]: begin
        alu_a    = req_a_1;
        alu_b    = req_b_1;
        alu_ctrl = req_ctrl_1;
      end
      default: begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = IDLE_CTRL;
      end
    endcase
  end

  // Reset value 1 lets port 0 win the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant[0]) begin
      last_grant <= 1'b0;
    end else if (grant[1]) begin
      last_grant <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid[0] <= 1'b0;
      resp_out_0    <= '0;
      resp_ovf[0]   <= 1'b0;
    end else if (grant[0]) begin
      resp_valid[0] <= 1'b1;
      resp_out_0    <= alu_out;
      resp_ovf[0]   <= alu_overflow;
    end else if (resp_valid[0] && resp_ready[0]) begin
      resp_valid[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid[1] <= 1'b0;
      resp_out_1    <= '0;
      resp_ovf[1]   <= 1'b0;
    end else if (grant[1]) begin
      resp_valid[1] <= 1'b1;
      resp_out_1    <= alu_out;
      resp_ovf[1]   <= alu_overflow;
    end else if (resp_valid[1] && resp_ready[1]) begin
      resp_valid[1] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small ALU model
// and per-port expected-response queues drained by a monitor.

`ifndef aluAdd
`define aluAdd 4'h0
`endif
`ifndef aluSub
`define aluSub 4'h1
`endif
`ifndef aluShiftLeft
`define aluShiftLeft 4'h2
`endif
`ifndef aluArithmeticShiftRight
`define aluArithmeticShiftRight 4'h3
`endif
`ifndef aluDisabled
`define aluDisabled 4'hF
`endif

module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic [3:0]  req_ctrl_0, req_ctrl_1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_out_0, resp_out_1;
  logic [1:0]  resp_ovf;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_ctrl;
  logic        alu_overflow;

  typedef struct {
    logic [31:0] d;
    logic        o;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  alu_arbiter dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a_0(req_a_0),
    .req_a_1(req_a_1),
    .req_b_0(req_b_0),
    .req_b_1(req_b_1),
    .req_ctrl_0(req_ctrl_0),
    .req_ctrl_1(req_ctrl_1),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_out_0(resp_out_0),
    .resp_out_1(resp_out_1),
    .resp_ovf(resp_ovf),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_ctrl(alu_ctrl),
    .alu_out(alu_out),
    .alu_overflow(alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU hooked to the shared ALU ports.
  always_comb begin
    logic [31:0] s;
    s = '0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      `aluAdd: begin
        s = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
      end
      `aluSub: begin
        s = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]);
      end
      `aluShiftLeft: s = alu_a << alu_b[4:0];
      `aluArithmeticShiftRight: s = $signed(alu_a) >>> alu_b[4:0];
      default: s = '0;
    endcase
    alu_out = s;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake consumes one expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid[0] && resp_ready[0]) begin
        if (q0.size() == 0) begin
          chk("resp0_unexpected", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q0.pop_front();
          chk("resp_out_0", {32'd0, resp_out_0}, {32'd0, e.d});
          chk("resp_ovf0", {63'd0, resp_ovf[0]}, {63'd0, e.o});
        end
      end
      if (resp_valid[1] && resp_ready[1]) begin
        if (q1.size() == 0) begin
          chk("resp1_unexpected", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("resp_out_1", {32'd0, resp_out_1}, {32'd0, e.d});
          chk("resp_ovf1", {63'd0, resp_ovf[1]}, {63'd0, e.o});
        end
      end
    end
  end

  task automatic push0(input logic [31:0] d, input logic o);
    exp_t e;
    e.d = d;
    e.o = o;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [31:0] d, input logic o);
    exp_t e;
    e.d = d;
    e.o = o;
    q1.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    req_a_0 = '0; req_b_0 = '0; req_ctrl_0 = `aluAdd;
    req_a_1 = '0; req_b_1 = '0; req_ctrl_1 = `aluAdd;

    // Reset state, with requests pending.
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
    chk("rst_resp_valid", {62'd0, resp_valid}, 64'd0);
    chk("rst_resp_out_0", {32'd0, resp_out_0}, 64'd0);
    chk("rst_resp_out_1", {32'd0, resp_out_1}, 64'd0);
    chk("rst_resp_ovf", {62'd0, resp_ovf}, 64'd0);
    reset_dut();

    // Single port-0 add.
    req_valid = 2'b01;
    req_a_0 = 32'd5; req_b_0 = 32'd7; req_ctrl_0 = `aluAdd;
    @(negedge clk);
    chk("add_ready", {62'd0, req_ready}, 64'b01);
    push0(32'd12, 1'b0);
    nxt();
    req_valid = 2'b00;
    @(negedge clk);
    chk("add_resp_valid", {62'd0, resp_valid}, 64'b01);
    nxt();
    @(negedge clk);
    chk("add_resp_drop", {62'd0, resp_valid}, 64'b00);

    // Contention from reset: strict alternation starting with port 0.
    reset_dut();
    req_valid = 2'b11;
    req_a_0 = 32'h7FFF_FFFF; req_b_0 = 32'd1; req_ctrl_0 = `aluAdd;
    req_a_1 = 32'd10; req_b_1 = 32'd3; req_ctrl_1 = `aluSub;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("rr_grant", {62'd0, req_ready}, 64'b01);
        push0(32'h8000_0000, 1'b1);
      end else begin
        chk("rr_grant", {62'd0, req_ready}, 64'b10);
        push1(32'd7, 1'b0);
      end
      nxt();
    end
    req_valid = 2'b00;
    repeat (2) nxt();

    // Port 1 backpressured while still requesting.
    reset_dut();
    resp_ready = 2'b01;
    req_valid  = 2'b11;
    req_a_0 = 32'd1; req_b_0 = 32'd2; req_ctrl_0 = `aluAdd;
    req_a_1 = 32'd100; req_b_1 = 32'd200; req_ctrl_1 = `aluAdd;
    @(negedge clk);
    chk("bp_first", {62'd0, req_ready}, 64'b01);
    push0(32'd3, 1'b0);
    nxt();
    @(negedge clk);
    chk("bp_second", {62'd0, req_ready}, 64'b10);
    push1(32'd300, 1'b0);
    nxt();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_p0_only", {62'd0, req_ready}, 64'b01);
      chk("bp_hold_valid", {63'd0, resp_valid[1]}, 64'd1);
      chk("bp_hold_out", {32'd0, resp_out_1}, 64'd300);
      push0(32'd3, 1'b0);
      nxt();
    end
    req_a_1 = 32'd5; req_b_1 = 32'd6;
    resp_ready = 2'b11;
    @(negedge clk);
    chk("bp_release", {62'd0, req_ready}, 64'b10);
    push1(32'd11, 1'b0);
    nxt();
    req_valid = 2'b00;
    @(negedge clk);
    chk("bp_no_gap", {63'd0, resp_valid[1]}, 64'd1);
    chk("bp_new_out", {32'd0, resp_out_1}, 64'd11);
    nxt();

    // Idle drive, then a lone port-1 request, then a tie.
    @(negedge clk);
    chk("idle_ctrl", {60'd0, alu_ctrl}, {60'd0, `aluDisabled});
    chk("idle_a", {32'd0, alu_a}, 64'd0);
    chk("idle_b", {32'd0, alu_b}, 64'd0);
    chk("idle_ready", {62'd0, req_ready}, 64'd0);
    nxt();
    req_valid = 2'b10;
    req_a_1 = 32'd20; req_b_1 = 32'd22; req_ctrl_1 = `aluAdd;
    @(negedge clk);
    chk("lone_p1", {62'd0, req_ready}, 64'b10);
    push1(32'd42, 1'b0);
    nxt();
    req_valid = 2'b11;
    req_a_0 = 32'd1; req_b_0 = 32'd1; req_ctrl_0 = `aluAdd;
    @(negedge clk);
    chk("tie_after_p1", {62'd0, req_ready}, 64'b01);
    push0(32'd2, 1'b0);
    nxt();
    req_valid = 2'b00;
    repeat (2) nxt();

    // Asynchronous reset discards an accepted shift.
    reset_dut();
    resp_ready = 2'b00;
    req_valid  = 2'b01;
    req_a_0 = 32'h8000_0000; req_b_0 = 32'd4;
    req_ctrl_0 = `aluArithmeticShiftRight;
    @(negedge clk);
    chk("sra_ready", {62'd0, req_ready}, 64'b01);
    chk("sra_alu_out", {32'd0, alu_out}, 64'hF800_0000);
    @(posedge clk);
    #1;
    chk("sra_accepted", {63'd0, resp_valid[0]}, 64'd1);
    req_valid = 2'b00;
    #1 reset = 1'b1;
    #1;
    chk("async_rst_valid", {62'd0, resp_valid}, 64'd0);
    chk("async_rst_out", {32'd0, resp_out_0}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    resp_ready = 2'b11;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_quiet", {62'd0, resp_valid}, 64'd0);
    end
    nxt();
    req_valid = 2'b11;
    req_a_0 = 32'd9; req_b_0 = 32'd4; req_ctrl_0 = `aluSub;
    req_a_1 = 32'd1; req_b_1 = 32'd1; req_ctrl_1 = `aluAdd;
    @(negedge clk);
    chk("post_rst_first", {62'd0, req_ready}, 64'b01);
    push0(32'd5, 1'b0);
    nxt();
    req_valid = 2'b00;
    repeat (2) nxt();

    // Shift-left captured and held until drained.
    resp_ready = 2'b01;
    req_valid  = 2'b10;
    req_a_1 = 32'd1; req_b_1 = 32'd31; req_ctrl_1 = `aluShiftLeft;
    @(negedge clk);
    chk("sll_ready", {62'd0, req_ready}, 64'b10);
    push1(32'h8000_0000, 1'b0);
    nxt();
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sll_hold_valid", {63'd0, resp_valid[1]}, 64'd1);
      chk("sll_hold_out", {32'd0, resp_out_1}, 64'h8000_0000);
      nxt();
    end
    resp_ready = 2'b11;
    nxt();
    @(negedge clk);
    chk("sll_drained", {62'd0, resp_valid}, 64'd0);

    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
